dmem_responder: RTL and testbench

Word-addressed data-memory responder serving the load/store requests the multicycle CPU FSM issues in its Memory stage. Accepts one request at a time over a valid/ready handshake, inserts a programmable wait-state count, then returns read data or a write acknowledgement over a second valid/ready handshake. Flags misaligned and out-of-range addresses instead of silently wrapping.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 21 ++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and the address-check helper for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Op encoding matches the CPU FSM's Read/Write parameters.
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

    // Full 30-bit word index is compared so high addresses never alias into the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return ((addr & ALIGN_MASK) != 32'd0) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word store; kept apart from the handshake logic so a vendor RAM can drop in.
module dmem_array #(
    parameter  int DEPTH = 256,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [IW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];

    // Read-before-write: rdata reflects the contents prior to a same-edge store.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[idx_i] <= wdata_i;
        rdata_o <= mem[idx_i];
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time, programmable wait states, error flag for bad addresses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;

    logic          idle;
    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    assign idle = (state_q == ST_IDLE);

    // With zero wait states the access happens on the acceptance edge, before the latch is loaded.
    assign mem_idx   = idle ? req_addr_i[IW+1:2] : idx_q;
    assign mem_wdata = idle ? req_wdata_i        : wdata_q;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (mem_idx),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    write_d = req_write_i;
                    idx_d   = req_addr_i[IW+1:2];
                    wdata_d = req_wdata_i;
                    err_d   = addr_err(req_addr_i, DEPTH);
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        mem_we  = (req_write_i == MEM_WRITE) && !err_d;
                    end else begin
                        cnt_d   = WAIT_LD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    mem_we  = (write_q == MEM_WRITE) && !err_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= MEM_READ;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o  = idle && rst_n_i;
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_error_o = resp_valid_o && err_q;
    assign resp_rdata_o = (resp_valid_o && (write_q == MEM_READ) && !err_q) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder against a transaction-level memory model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_write = 0, resp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;

    logic        req_valid0 = 0, req_write0 = 0, resp_ready0 = 0;
    logic [31:0] req_addr0 = 0, req_wdata0 = 0;
    logic        req_ready0, resp_valid0, resp_error0;
    logic [31:0] resp_rdata0;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_error_o(resp_error)
    );

    dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_write_i(req_write0),
        .req_addr_i(req_addr0), .req_wdata_i(req_wdata0),
        .resp_valid_o(resp_valid0), .resp_ready_i(resp_ready0),
        .resp_rdata_o(resp_rdata0), .resp_error_o(resp_error0)
    );

    int unsigned n_total = 0, n_pass = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    // Transaction model: one outstanding request, response visible W edges after acceptance.
    logic [31:0] mm [int];
    bit          busy = 0, m_wr = 0, m_err = 0, rd_known = 0, chk_en = 0;
    int          cyc = 0, due = 0, m_idx = 0;
    logic [31:0] m_wdata = 0, m_rdata = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 0;
        end else begin
            bit shown;
            shown = busy && (cyc >= due);
            cyc++;
            if (shown && resp_ready) begin
                busy = 0;
            end else if (!busy && req_valid) begin
                busy    = 1;
                due     = cyc + W;
                m_wr    = req_write;
                m_idx   = int'(req_addr / 4);
                m_err   = (req_addr % 4 != 0) || (req_addr / 4 >= DEPTH);
                m_wdata = req_wdata;
            end
            if (busy && cyc == due) begin
                rd_known = 1;
                m_rdata  = 32'd0;
                if (m_wr) begin
                    if (!m_err) mm[m_idx] = m_wdata;
                end else if (!m_err) begin
                    if (mm.exists(m_idx)) m_rdata = mm[m_idx];
                    else rd_known = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                check("rst_req_ready", req_ready, 0);
                check("rst_resp_valid", resp_valid, 0);
                check("rst_resp_rdata", resp_rdata, 0);
                check("rst_resp_error", resp_error, 0);
            end else begin
                bit v;
                v = busy && (cyc >= due);
                check("req_ready", req_ready, !busy);
                check("resp_valid", resp_valid, v);
                check("resp_error", resp_error, v ? m_err : 1'b0);
                if (!v || rd_known) check("resp_rdata", resp_rdata, v ? m_rdata : 32'd0);
            end
        end
    end

    logic [31:0] rd;
    bit          er;
    int          lat;

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input int hold,
                          output logic [31:0] o_rd, output bit o_er, output int o_lat);
        int guard;
        @(negedge clk);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; resp_ready = 0;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) check("accept_timeout", 0, 1);
        @(negedge clk);
        req_valid = 0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        o_lat = 1;
        while (!resp_valid && o_lat < 40) begin @(negedge clk); o_lat++; end
        repeat (hold) @(negedge clk);
        o_rd = resp_rdata; o_er = resp_error;
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic step0(string nm, bit rr, bit rv, logic [31:0] exp_rd);
        @(negedge clk);
        check({nm, "_rr"}, req_ready0, rr);
        check({nm, "_rv"}, resp_valid0, rv);
        check({nm, "_rd"}, resp_rdata0, exp_rd);
        check({nm, "_err"}, resp_error0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_rdata", resp_rdata, 0);
        check("reset_resp_error", resp_error, 0);
        #2 rst_n = 1;
        @(negedge clk);
        check("post_reset_ready", req_ready, 1);
        chk_en = 1;

        // Zero wait states, resp_ready tied high, request held valid throughout.
        resp_ready0 = 1;
        step0("w0_idle", 1, 0, 0);
        req_valid0 = 1; req_write0 = 1; req_addr0 = 32'h0; req_wdata0 = 32'h1111_1111;
        step0("w0_sw0", 0, 1, 0);
        req_addr0 = 32'h4; req_wdata0 = 32'h2222_2222;
        step0("w0_gap1", 1, 0, 0);
        step0("w0_sw4", 0, 1, 0);
        req_write0 = 0; req_addr0 = 32'h0;
        step0("w0_gap2", 1, 0, 0);
        step0("w0_lw0", 0, 1, 32'h1111_1111);
        req_addr0 = 32'h4;
        step0("w0_gap3", 1, 0, 0);
        step0("w0_lw4", 0, 1, 32'h2222_2222);
        req_valid0 = 0;
        step0("w0_done", 1, 0, 0);

        for (int i = 0; i < 8; i++) do_req(1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 0, rd, er, lat);
        do_req(1, 32'h20, 32'hA5A5_A5A5, 0, rd, er, lat);

        do_req(1, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
        check("sw_latency", lat, 3);
        check("sw_err", er, 0);
        check("sw_rdata", rd, 0);
        do_req(0, 32'h10, 0, 0, rd, er, lat);
        check("lw_rdata", rd, 32'hDEAD_BEEF);
        check("lw_latency", lat, 3);

        do_req(0, 32'h13, 0, 0, rd, er, lat);
        check("misalign_err", er, 1);
        check("misalign_rdata", rd, 0);
        do_req(0, 32'h10, 0, 0, rd, er, lat);
        check("misalign_mem_kept", rd, 32'hDEAD_BEEF);

        do_req(1, 32'h400, 32'h1, 0, rd, er, lat);
        check("oor_err", er, 1);
        do_req(0, 32'h0, 0, 0, rd, er, lat);
        check("oor_no_alias", rd, 32'hC0DE_0000);

        do_req(0, 32'h10, 0, 5, rd, er, lat);
        check("bp_rdata", rd, 32'hDEAD_BEEF);
        check("bp_ready_after", req_ready, 1);

        // Store aborted by reset while still waiting.
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(negedge clk);
        req_valid = 0;
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("abort_req_ready", req_ready, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_resp_rdata", resp_rdata, 0);
        check("abort_resp_error", resp_error, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        do_req(0, 32'h20, 0, 0, rd, er, lat);
        check("abort_store_dropped", rd, 32'hA5A5_A5A5);

        repeat (800) begin
            @(negedge clk);
            req_valid  = 1'($urandom);
            req_write  = 1'($urandom);
            req_wdata  = $urandom;
            resp_ready = ($urandom % 3) != 0;
            case ($urandom % 8)
                0:       req_addr = (($urandom % 8) << 2) | $urandom_range(1, 3);
                1:       req_addr = 32'(DEPTH * 4) + (($urandom % 16) << 2);
                2:       req_addr = $urandom | 32'h8000_0000;
                default: req_addr = ($urandom % 8) << 2;
            endcase
        end
        @(negedge clk);
        req_valid = 0; resp_ready = 1;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
